inst_bus_if: RTL and testbench
==============================

INST_BUS_IF -- requirements
Module: inst_bus_if

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 stall  in  6  pipeline stall vector; any nonzero bit means the pipeline is holding.
REQ-004 flush  in  1  pipeline flush (exception redirect); aborts any fetch in progress.
REQ-005 cpu_ce_i  in  1  fetch enable from the PC generator; 1 means a fetch is requested.
REQ-006 cpu_addr_i  in  32  fetch address (PC), word aligned.
REQ-007 cpu_data_o  out  32  fetched instruction to the IF/ID pipeline register.
REQ-008 stallreq_o  out  1  request to stall the pipeline while the fetch is outstanding.
REQ-009 wb_adr_o  out  32  Wishbone address.
REQ-010 wb_dat_i  in  32  Wishbone read data.
REQ-011 wb_ack_i  in  1  Wishbone acknowledge.
REQ-012 wb_cyc_o, wb_stb_o  out  1 each  Wishbone cycle and strobe, always driven equal.
REQ-013 wb_we_o  out  1  constant 0 (read-only master).
REQ-014 wb_sel_o  out  4  4'b1111 while stb is high, 4'b0000 otherwise.

Function
REQ-015 FSM states: IDLE, BUSY, WAIT_FOR_STALL; the state is registered.
REQ-016 IDLE with cpu_ce_i=1 and flush=0: next edge latches wb_adr_o<=cpu_addr_i and sets cyc/stb/sel, then the FSM enters BUSY.
REQ-017 IDLE with cpu_ce_i=0 or flush=1: the FSM stays in IDLE and the bus stays idle.
REQ-018 BUSY with wb_ack_i=1 and flush=0: next edge clears cyc/stb/sel, clears wb_adr_o to 0, and sets rd_buf<=wb_dat_i.
REQ-019 After REQ-018: next state is WAIT_FOR_STALL if stall!=0, else IDLE.
REQ-020 BUSY with flush=1 (with or without ack): next edge clears cyc/stb/sel/adr, sets rd_buf<=0, and enters IDLE; any returned data is discarded.
REQ-021 BUSY with wb_ack_i=0 and flush=0: all bus outputs hold and the FSM stays in BUSY.
REQ-022 WAIT_FOR_STALL: stall==0 returns the FSM to IDLE; flush=1 also returns it to IDLE and clears rd_buf; otherwise the FSM holds.
REQ-023 stallreq_o (combinational): IDLE -> cpu_ce_i & ~flush; BUSY -> ~wb_ack_i; WAIT_FOR_STALL -> 0.
REQ-024 cpu_data_o (combinational): IDLE -> 0; BUSY -> wb_dat_i when wb_ack_i=1, else 0; WAIT_FOR_STALL -> rd_buf.
REQ-025 Fetch latency: instruction presented in the ack cycle (zero added latency); minimum of 2 cycles from request to data, since the request is registered.
REQ-026 At most one outstanding transaction; a new request is accepted only in IDLE.
REQ-027 wb_ack_i outside BUSY is ignored.

Reset
REQ-028 When rst=1 at a rising edge: state<=IDLE; wb_adr_o, rd_buf <= 0; cyc/stb <= 0; sel <= 0.
REQ-029 Reset mid-transaction abandons the bus cycle immediately; the returned ack is ignored per REQ-027.
REQ-030 During reset, cpu_ce_i is 0, so stallreq_o and cpu_data_o are 0.

Structure
REQ-031 State encodings, the RegBus/InstAddrBus widths, and the Stop/NoStop and ChipEnable constants come from the shared defines file; no local literals for these.
REQ-032 The block is a single flat module with no sub-module; the same FSM is reused for the data-side bus interface by instantiation.

Verification
REQ-033 Reset: assert rst for 2 cycles during BUSY -> after reset, state IDLE, stb=0, adr=0, stallreq_o=0.
REQ-034 Single fetch: ce=1, pc=0x00000040, mem[0x40]=0x34011100, ack 3 cycles later -> stallreq_o high until the ack cycle; cpu_data_o=0x34011100 in the ack cycle; stb low the next cycle.
REQ-035 Stall hold: ack arrives with stall=6'b000011 held for 4 cycles -> FSM in WAIT_FOR_STALL; cpu_data_o stays 0x34011100 and stallreq_o=0; FSM returns to IDLE when stall clears.
REQ-036 Flush abort: flush=1 in the 2nd BUSY cycle with ack=0 -> stb drops next cycle; later ack is ignored; cpu_data_o=0; the next fetch of new_pc=0x00000020 completes normally.
REQ-037 Flush with ack: flush=1 and ack=1 in the same cycle -> data is discarded, rd_buf=0, FSM returns to IDLE.
REQ-038 Back-to-back fetches: 0x0, 0x4, 0x8 with a 1-cycle ack -> three bus cycles; wb_sel_o=4'hF while stb is high; wb_we_o is always 0.

Source files
------------

// File: rtl/inst_bus_if_pkg.sv
// Shared definitions for the instruction-side Wishbone bus interface:
// bus widths, FSM state encodings and pipeline control constants.
package inst_bus_if_pkg;

  localparam int REG_BUS_W       = 32;
  localparam int INST_ADDR_BUS_W = 32;
  localparam int STALL_W         = 6;
  localparam int SEL_W           = 4;

  localparam logic STOP        = 1'b1;
  localparam logic NO_STOP     = 1'b0;
  localparam logic CHIP_ENABLE = 1'b1;

  localparam logic [SEL_W-1:0]           SEL_ALL   = 4'b1111;
  localparam logic [SEL_W-1:0]           SEL_NONE  = 4'b0000;
  localparam logic [REG_BUS_W-1:0]       ZERO_WORD = '0;
  localparam logic [INST_ADDR_BUS_W-1:0] ZERO_ADDR = '0;

  typedef enum logic [1:0] {
    IDLE           = 2'd0,
    BUSY           = 2'd1,
    WAIT_FOR_STALL = 2'd2
  } bus_state_e;

  // True when any stage of the pipeline is holding.
  function automatic logic pipe_held(input logic [STALL_W-1:0] stall);
    return |stall;
  endfunction

endpackage

// File: rtl/inst_bus_if.sv
// Instruction-fetch Wishbone master. Issues one read per fetch request,
// stalls the pipeline while the read is outstanding, and keeps the fetched
// word in rd_buf if the pipeline is still holding when the ack arrives.
module inst_bus_if
  import inst_bus_if_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [STALL_W-1:0]         stall,
  input  logic                       flush,
  input  logic                       cpu_ce_i,
  input  logic [INST_ADDR_BUS_W-1:0] cpu_addr_i,
  output logic [REG_BUS_W-1:0]       cpu_data_o,
  output logic                       stallreq_o,
  output logic [INST_ADDR_BUS_W-1:0] wb_adr_o,
  input  logic [REG_BUS_W-1:0]       wb_dat_i,
  input  logic                       wb_ack_i,
  output logic                       wb_cyc_o,
  output logic                       wb_stb_o,
  output logic                       wb_we_o,
  output logic [SEL_W-1:0]           wb_sel_o
);

  bus_state_e                 state_q;
  bus_state_e                 state_d;
  logic                       bus_req_q;
  logic [SEL_W-1:0]           sel_q;
  logic [INST_ADDR_BUS_W-1:0] adr_q;
  logic [REG_BUS_W-1:0]       rd_buf;
  logic                       fetch_go;

  // A fetch is launched only from IDLE and never in a flush cycle.
  assign fetch_go = (cpu_ce_i == CHIP_ENABLE) && !flush;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush always wins and returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fetch_go) state_d = BUSY;
      end
      BUSY: begin
        if (flush)                  state_d = IDLE;
        else if (wb_ack_i)          state_d = pipe_held(stall) ? WAIT_FOR_STALL : IDLE;
      end
      WAIT_FOR_STALL: begin
        if (flush || !pipe_held(stall)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered bus request, address and read buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req_q <= 1'b0;
      sel_q     <= SEL_NONE;
      adr_q     <= ZERO_ADDR;
      rd_buf    <= ZERO_WORD;
    end else begin
      case (state_q)
        IDLE: begin
          if (fetch_go) begin
            bus_req_q <= 1'b1;
            sel_q     <= SEL_ALL;
            adr_q     <= cpu_addr_i;
          end
        end
        BUSY: begin
          if (flush) begin
            bus_req_q <= 1'b0;
            sel_q     <= SEL_NONE;
            adr_q     <= ZERO_ADDR;
            rd_buf    <= ZERO_WORD;
          end else if (wb_ack_i) begin
            bus_req_q <= 1'b0;
            sel_q     <= SEL_NONE;
            adr_q     <= ZERO_ADDR;
            rd_buf    <= wb_dat_i;
          end
        end
        WAIT_FOR_STALL: begin
          if (flush) rd_buf <= ZERO_WORD;
        end
        default: begin
          bus_req_q <= 1'b0;
          sel_q     <= SEL_NONE;
          adr_q     <= ZERO_ADDR;
        end
      endcase
    end
  end

  // Pipeline-facing outputs; the fetched word bypasses rd_buf in the ack cycle.
  always_comb begin
    stallreq_o = NO_STOP;
    cpu_data_o = ZERO_WORD;
    case (state_q)
      IDLE: begin
        stallreq_o = fetch_go ? STOP : NO_STOP;
      end
      BUSY: begin
        stallreq_o = wb_ack_i ? NO_STOP : STOP;
        cpu_data_o = wb_ack_i ? wb_dat_i : ZERO_WORD;
      end
      WAIT_FOR_STALL: begin
        cpu_data_o = rd_buf;
      end
      default: begin
        stallreq_o = NO_STOP;
        cpu_data_o = ZERO_WORD;
      end
    endcase
  end

  assign wb_cyc_o = bus_req_q;
  assign wb_stb_o = bus_req_q;
  assign wb_sel_o = sel_q;
  assign wb_adr_o = adr_q;
  assign wb_we_o  = 1'b0;

endmodule

// File: tb/tb_inst_bus_if.sv
// Directed bench for inst_bus_if: reset, single fetch, stall hold,
// flush abort, flush with ack, flush during stall hold, back-to-back fetches
// and reset in the middle of a bus cycle.
module tb_inst_bus_if;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        cpu_ce_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_data_o;
  logic        stallreq_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;

  int errors = 0;
  int checks = 0;

  inst_bus_if dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .flush     (flush),
    .cpu_ce_i  (cpu_ce_i),
    .cpu_addr_i(cpu_addr_i),
    .cpu_data_o(cpu_data_o),
    .stallreq_o(stallreq_o),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_i  (wb_dat_i),
    .wb_ack_i  (wb_ack_i),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_we_o   (wb_we_o),
    .wb_sel_o  (wb_sel_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bus outputs in one go: stb/cyc, sel, adr, and we always 0.
  task automatic check_bus(input string tag, input logic stb, input logic [31:0] adr);
    check({tag, "_stb"}, {31'd0, wb_stb_o}, {31'd0, stb});
    check({tag, "_cyc"}, {31'd0, wb_cyc_o}, {31'd0, stb});
    check({tag, "_sel"}, {28'd0, wb_sel_o}, stb ? 32'hF : 32'h0);
    check({tag, "_adr"}, wb_adr_o, adr);
    check({tag, "_we"},  {31'd0, wb_we_o}, 32'd0);
  endtask

  task automatic check_cpu(input string tag, input logic sreq, input logic [31:0] data);
    check({tag, "_stallreq"}, {31'd0, stallreq_o}, {31'd0, sreq});
    check({tag, "_data"}, cpu_data_o, data);
  endtask

  initial begin
    rst = 1'b1; stall = 6'd0; flush = 1'b0; cpu_ce_i = 1'b0;
    cpu_addr_i = 32'd0; wb_dat_i = 32'd0; wb_ack_i = 1'b0;
    tick(); tick();
    check_bus("rst_hold", 1'b0, 32'h0);
    check_cpu("rst_hold", 1'b0, 32'h0);
    rst = 1'b0;
    tick();
    check_bus("post_rst", 1'b0, 32'h0);
    check_cpu("post_rst", 1'b0, 32'h0);

    // Single fetch, ack in the third BUSY cycle.
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_0040;
    settle();
    check_cpu("sf_req", 1'b1, 32'h0);
    check_bus("sf_req", 1'b0, 32'h0);
    tick();
    check_bus("sf_busy1", 1'b1, 32'h40);
    check_cpu("sf_busy1", 1'b1, 32'h0);
    tick();
    check_cpu("sf_busy2", 1'b1, 32'h0);
    tick();
    wb_ack_i = 1'b1; wb_dat_i = 32'h3401_1100;
    settle();
    check_cpu("sf_ack", 1'b0, 32'h3401_1100);
    check_bus("sf_ack", 1'b1, 32'h40);
    tick();
    wb_ack_i = 1'b0; wb_dat_i = 32'h0; cpu_ce_i = 1'b0;
    settle();
    check_bus("sf_after", 1'b0, 32'h0);
    check_cpu("sf_after", 1'b0, 32'h0);

    // Ack while the pipeline holds: word kept until stall clears.
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_0040;
    tick();
    cpu_ce_i = 1'b0;
    wb_ack_i = 1'b1; wb_dat_i = 32'h3401_1100; stall = 6'b000011;
    settle();
    check_cpu("sh_ack", 1'b0, 32'h3401_1100);
    tick();
    wb_ack_i = 1'b0; wb_dat_i = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_cpu("sh_wait", 1'b0, 32'h3401_1100);
      check_bus("sh_wait", 1'b0, 32'h0);
      tick();
    end
    stall = 6'd0;
    settle();
    check_cpu("sh_release", 1'b0, 32'h3401_1100);
    tick();
    check_cpu("sh_idle", 1'b0, 32'h0);
    cpu_ce_i = 1'b1;
    settle();
    check_cpu("sh_idle_ce", 1'b1, 32'h0);
    cpu_ce_i = 1'b0;
    settle();

    // Flush in the second BUSY cycle without ack.
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_0080;
    tick();
    cpu_ce_i = 1'b0;
    check_bus("fa_busy1", 1'b1, 32'h80);
    tick();
    flush = 1'b1;
    settle();
    check_cpu("fa_flush", 1'b1, 32'h0);
    tick();
    flush = 1'b0;
    settle();
    check_bus("fa_dropped", 1'b0, 32'h0);
    wb_ack_i = 1'b1; wb_dat_i = 32'h1111_1111;
    settle();
    check_cpu("fa_late_ack", 1'b0, 32'h0);
    tick();
    wb_ack_i = 1'b0;
    settle();
    check_bus("fa_still_idle", 1'b0, 32'h0);
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_0020;
    tick();
    cpu_ce_i = 1'b0;
    check_bus("fa_new_busy", 1'b1, 32'h20);
    wb_ack_i = 1'b1; wb_dat_i = 32'h0022_1020;
    settle();
    check_cpu("fa_new_ack", 1'b0, 32'h0022_1020);
    tick();
    wb_ack_i = 1'b0;
    settle();
    check_bus("fa_new_done", 1'b0, 32'h0);

    // Flush and ack together with a held pipeline: data discarded, back to IDLE.
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_0100;
    tick();
    cpu_ce_i = 1'b0;
    wb_ack_i = 1'b1; flush = 1'b1; wb_dat_i = 32'hCAFE_F00D; stall = 6'b000001;
    settle();
    check_cpu("fk_cycle", 1'b0, 32'hCAFE_F00D);
    tick();
    wb_ack_i = 1'b0; flush = 1'b0;
    settle();
    check_cpu("fk_idle", 1'b0, 32'h0);
    check_bus("fk_idle", 1'b0, 32'h0);
    cpu_ce_i = 1'b1;
    settle();
    check_cpu("fk_idle_ce", 1'b1, 32'h0);
    cpu_ce_i = 1'b0;
    stall = 6'd0;
    settle();

    // Flush while waiting for the stall to clear.
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_0200;
    tick();
    cpu_ce_i = 1'b0;
    wb_ack_i = 1'b1; wb_dat_i = 32'h8C22_0004; stall = 6'b100000;
    tick();
    wb_ack_i = 1'b0;
    settle();
    check_cpu("fw_wait", 1'b0, 32'h8C22_0004);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    settle();
    check_cpu("fw_idle", 1'b0, 32'h0);
    stall = 6'd0;
    settle();

    // Back-to-back fetches with single-cycle ack.
    cpu_ce_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cpu_addr_i = 32'(i * 4);
      settle();
      check_cpu("bb_req", 1'b1, 32'h0);
      tick();
      check_bus("bb_busy", 1'b1, 32'(i * 4));
      wb_ack_i = 1'b1; wb_dat_i = 32'h2000_0000 + 32'(i);
      settle();
      check_cpu("bb_ack", 1'b0, 32'h2000_0000 + 32'(i));
      tick();
      wb_ack_i = 1'b0;
      settle();
      check_bus("bb_gap", 1'b0, 32'h0);
    end
    cpu_ce_i = 1'b0;
    settle();

    // Reset for two cycles in the middle of a bus cycle.
    cpu_ce_i = 1'b1; cpu_addr_i = 32'h0000_0300;
    tick();
    check_bus("mr_busy", 1'b1, 32'h300);
    cpu_ce_i = 1'b0; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    settle();
    check_bus("mr_after", 1'b0, 32'h0);
    check_cpu("mr_after", 1'b0, 32'h0);
    wb_ack_i = 1'b1; wb_dat_i = 32'h5555_AAAA;
    settle();
    check_cpu("mr_stray_ack", 1'b0, 32'h0);
    tick();
    wb_ack_i = 1'b0;
    settle();
    check_bus("mr_stray_done", 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
